// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared constants and types for the multi-cycle sequencer
// Opcode and func encodings, sequencer state encoding and instruction classes.
package ctrl_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] F_ADD = 5'b00000;
    localparam logic [4:0] F_SUB = 5'b00001;
    localparam logic [4:0] F_AND = 5'b00010;
    localparam logic [4:0] F_OR  = 5'b00011;
    localparam logic [4:0] F_SLL = 5'b00100;
    localparam logic [4:0] F_SRA = 5'b00101;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NOP   = 3'd0,
        C_RTYPE = 3'd1,
        C_ADDI  = 3'd2,
        C_SW    = 3'd3,
        C_LW    = 3'd4
    } iclass_t;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational opcode/func to instruction-class decoder
// Ports:
//   opcode  in   IR opcode field
//   func    in   IR ALU-op field
//   cls     out  instruction class (C_NOP when illegal)
//   illegal out  unsupported opcode, or R-type with func beyond F_SRA
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic [4:0] func,
    output iclass_t    cls,
    output logic       illegal
);

    always_comb begin
        cls     = C_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (func <= F_SRA) cls = C_RTYPE;
                else               illegal = 1'b1;
            end
            OP_ADDI: cls = C_ADDI;
            OP_SW:   cls = C_SW;
            OP_LW:   cls = C_LW;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   opcode, func          IR fields, valid from the cycle after ir_we
//   imem_ack, dmem_ack    memory handshakes
//   imem_req, dmem_req    memory requests
//   ir_we, pc_we          IR load, PC advance
//   Rwe, Rdst, ALUinB     register write, rd select, immediate on ALU B
//   ALUop, DMwe, Rwd      ALU operation, data-memory write, write-back from memory
//   fault                 sticky fault (illegal instruction or memory timeout)
//   retired               retired-instruction count, wraps
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       opcode,
    input  logic [4:0]       func,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic             Rwe,
    output logic             Rdst,
    output logic             ALUinB,
    output logic [4:0]       ALUop,
    output logic             DMwe,
    output logic             Rwd,
    output logic             fault,
    output logic [CNT_W-1:0] retired
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state, state_next;
    iclass_t           cls_q, dec_cls;
    logic              dec_illegal;
    logic [4:0]        func_q;
    logic [WAIT_W-1:0] wcnt;
    logic [CNT_W-1:0]  ret_q;
    logic              retire;
    logic              timed_out;

    instr_decode u_decode (
        .opcode  (opcode),
        .func    (func),
        .cls     (dec_cls),
        .illegal (dec_illegal)
    );

    assign timed_out = (wcnt == WAIT_LAST);
    assign retired   = reset ? '0 : ret_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= S_FETCH;
            cls_q  <= C_NOP;
            func_q <= 5'b0;
            wcnt   <= '0;
            ret_q  <= '0;
        end else begin
            state <= state_next;
            // Class and func are captured once so the datapath controls stay
            // stable through EXEC..WB regardless of later IR activity.
            if (state == S_DECODE) begin
                cls_q  <= dec_cls;
                func_q <= func;
            end
            if (retire) ret_q <= ret_q + CNT_W'(1);
            if (state_next != state)
                wcnt <= '0;
            else if (state == S_FETCH || state == S_MEM)
                wcnt <= wcnt + WAIT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        Rwe        = 1'b0;
        Rdst       = 1'b0;
        ALUinB     = 1'b0;
        ALUop      = 5'b0;
        DMwe       = 1'b0;
        Rwd        = 1'b0;
        fault      = 1'b0;
        retire     = 1'b0;

        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            ALUinB = (cls_q == C_ADDI) || (cls_q == C_SW) || (cls_q == C_LW);
            ALUop  = ALUinB ? 5'b0 : func_q;
            Rdst   = (cls_q == C_RTYPE);
        end

        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                // An ack in the last allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end else if (timed_out) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: state_next = dec_illegal ? S_FAULT : S_EXEC;
            S_EXEC:   state_next = (cls_q == C_SW || cls_q == C_LW) ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                DMwe     = (cls_q == C_SW);
                if (dmem_ack) begin
                    if (cls_q == C_SW) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end else if (timed_out) begin
                    state_next = S_FAULT;
                end
            end
            S_WB: begin
                Rwe        = 1'b1;
                pc_we      = 1'b1;
                Rwd        = (cls_q == C_LW);
                retire     = 1'b1;
                state_next = S_FETCH;
            end
            S_FAULT:  fault = 1'b1;
            default:  state_next = S_FAULT;
        endcase

        if (reset) begin
            imem_req = 1'b0;
            dmem_req = 1'b0;
            ir_we    = 1'b0;
            pc_we    = 1'b0;
            Rwe      = 1'b0;
            Rdst     = 1'b0;
            ALUinB   = 1'b0;
            ALUop    = 5'b0;
            DMwe     = 1'b0;
            Rwd      = 1'b0;
            fault    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    localparam int TO = 4;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [4:0]    opcode = 5'b0;
    logic [4:0]    func = 5'b0;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          imem_req, dmem_req, ir_we, pc_we, Rwe, Rdst, ALUinB, DMwe, Rwd, fault;
    logic [4:0]    ALUop;
    logic [CW-1:0] retired;

    always #5 clock = ~clock;

    multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock    (clock),
        .reset    (reset),
        .opcode   (opcode),
        .func     (func),
        .imem_ack (imem_ack),
        .dmem_ack (dmem_ack),
        .imem_req (imem_req),
        .dmem_req (dmem_req),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .Rwe      (Rwe),
        .Rdst     (Rdst),
        .ALUinB   (ALUinB),
        .ALUop    (ALUop),
        .DMwe     (DMwe),
        .Rwd      (Rwd),
        .fault    (fault),
        .retired  (retired)
    );

    // One record per clock cycle: inputs to drive and the outputs they must produce.
    typedef struct {
        logic        rst;
        logic        ia;
        logic        da;
        logic [4:0]  op;
        logic [4:0]  fn;
        logic [18:0] exp;
        int          tag;
    } rec_t;

    rec_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ret_m = 0;
    bit   faulted = 0;
    int   cur = 0;
    bit   active = 0;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [4:0] r5();
        return 5'($urandom_range(0, 31));
    endfunction

    // Output vector order: imem_req dmem_req ir_we pc_we Rwe Rdst ALUinB ALUop DMwe Rwd fault retired
    function automatic logic [18:0] ev(logic imr, logic dmr, logic irw, logic pcw, logic rwe,
                                       logic rdst, logic aib, logic [4:0] aop, logic dmwe,
                                       logic rwd, logic flt, int ret);
        return {imr, dmr, irw, pcw, rwe, rdst, aib, aop, dmwe, rwd, flt, CW'(ret)};
    endfunction

    task automatic push(logic rst, logic ia, logic da, logic [4:0] op, logic [4:0] fn, logic [18:0] e);
        rec_t r;
        r.rst = rst; r.ia = ia; r.da = da; r.op = op; r.fn = fn; r.exp = e; r.tag = 0;
        q.push_back(r);
    endtask

    task automatic gen_reset(int n);
        for (int i = 0; i < n; i++) push(1'b1, rb(), rb(), r5(), r5(), '0);
        ret_m = 0;
        faulted = 0;
    endtask

    task automatic gen_fault(int n);
        for (int i = 0; i < n; i++)
            push(1'b0, rb(), rb(), r5(), r5(), ev(0,0,0,0,0,0,0,5'd0,0,0,1,ret_m));
    endtask

    // Expected trace of one instruction. wf/wm = wait cycles before ack;
    // a wait of TO or more means the ack never arrives in time.
    task automatic gen_instr(logic [4:0] op, logic [4:0] fn, int wf, int wm);
        logic       legal, is_mem, is_sw, is_lw, aib, rdst;
        logic [4:0] aop;
        int         nf, nm;
        legal  = (op == 5'd0 && fn <= 5'd5) || op == 5'd5 || op == 5'd7 || op == 5'd8;
        is_sw  = (op == 5'd7);
        is_lw  = (op == 5'd8);
        is_mem = is_sw || is_lw;
        aib    = (op != 5'd0);
        aop    = aib ? 5'd0 : fn;
        rdst   = (op == 5'd0);
        nf     = (wf < TO) ? wf : TO;
        for (int i = 0; i < nf; i++)
            push(1'b0, 1'b0, rb(), r5(), r5(), ev(1,0,0,0,0,0,0,5'd0,0,0,0,ret_m));
        if (wf >= TO) begin faulted = 1; return; end
        push(1'b0, 1'b1, rb(), r5(), r5(), ev(1,0,1,0,0,0,0,5'd0,0,0,0,ret_m));
        push(1'b0, rb(), rb(), op, fn, ev(0,0,0,0,0,0,0,5'd0,0,0,0,ret_m));
        if (!legal) begin faulted = 1; return; end
        push(1'b0, rb(), rb(), op, fn, ev(0,0,0,0,0,rdst,aib,aop,0,0,0,ret_m));
        if (is_mem) begin
            nm = (wm < TO) ? wm : TO;
            for (int i = 0; i < nm; i++)
                push(1'b0, rb(), 1'b0, op, fn, ev(0,1,0,0,0,rdst,aib,aop,is_sw,0,0,ret_m));
            if (wm >= TO) begin faulted = 1; return; end
            if (is_sw) begin
                push(1'b0, rb(), 1'b1, op, fn, ev(0,1,0,1,0,rdst,aib,aop,1,0,0,ret_m));
                ret_m++;
                return;
            end
            push(1'b0, rb(), 1'b1, op, fn, ev(0,1,0,0,0,rdst,aib,aop,0,0,0,ret_m));
        end
        push(1'b0, rb(), rb(), op, fn, ev(0,0,0,1,1,rdst,aib,aop,0,is_lw,0,ret_m));
        ret_m++;
    endtask

    task automatic run_instr(logic [4:0] op, logic [4:0] fn, int wf, int wm);
        gen_instr(op, fn, wf, wm);
        if (faulted) begin
            gen_fault($urandom_range(1, 3));
            gen_reset($urandom_range(1, 2));
        end
    endtask

    // Instruction cut short by reset after 'cut' cycles.
    task automatic gen_abort(logic [4:0] op, logic [4:0] fn, int wf, int wm, int cut);
        int b;
        b = q.size();
        gen_instr(op, fn, wf, wm);
        while (q.size() > b + cut) void'(q.pop_back());
        gen_reset(1);
    endtask

    task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, want);
        end
    endtask

    always @(negedge clock) begin
        if (active) begin
            rec_t        r;
            logic [18:0] got;
            r   = q[cur];
            got = {imem_req, dmem_req, ir_we, pc_we, Rwe, Rdst, ALUinB, ALUop, DMwe, Rwd, fault, retired};
            checks++;
            if (got !== r.exp) begin
                errors++;
                $display("FAIL outs cycle %0d: got %05h expected %05h", cur, got, r.exp);
            end
            case (r.tag)
                1: chk("sub_wb", {23'd0, Rwe, Rdst, pc_we, ALUinB, ALUop}, 32'b1_1_1_0_00001);
                2: chk("sub_retired", {27'd0, imem_req, retired}, {27'd0, 1'b1, 4'd1});
                3: chk("lw_wb", {24'd0, Rwe, Rwd, ALUinB, ALUop}, 32'b1_1_1_00000);
                4: chk("illegal_fault", {26'd0, fault, imem_req, retired}, {26'd0, 1'b1, 1'b0, 4'd4});
                5: chk("fetch_timeout", {31'd0, fault}, 32'd1);
                6: chk("after_abort", {27'd0, imem_req, retired}, {27'd0, 1'b1, 4'd0});
                7: chk("retired_wrap", {28'd0, retired}, 32'd0);
                default: ;
            endcase
        end
    end

    initial begin
        int b;
        int lw_len;
        int x, wf, wm;
        logic [4:0] op, fn;

        gen_reset(2);
        run_instr(5'd0, 5'd1, 0, 0);
        q[q.size()-1].tag = 1;
        b = q.size();
        run_instr(5'd5, 5'd9, 0, 0);
        q[b].tag = 2;
        b = q.size();
        run_instr(5'd8, 5'd3, 0, 3);
        lw_len = q.size() - b;
        q[q.size()-1].tag = 3;
        run_instr(5'd7, 5'd0, 1, 1);
        gen_instr(5'd31, 5'd0, 0, 0);
        b = q.size();
        gen_fault(3);
        q[b].tag = 4;
        gen_reset(1);
        run_instr(5'd0, 5'd6, 0, 0);
        gen_instr(5'd5, 5'd0, 4, 0);
        b = q.size();
        gen_fault(2);
        q[b].tag = 5;
        gen_reset(1);
        run_instr(5'd5, 5'd0, 3, 0);
        run_instr(5'd8, 5'd0, 0, 4);
        run_instr(5'd7, 5'd0, 0, 3);
        gen_abort(5'd8, 5'd0, 0, 3, 4);
        b = q.size();
        run_instr(5'd5, 5'd0, 0, 0);
        q[b].tag = 6;
        for (int i = 0; i < 15; i++) run_instr(5'd5, r5(), 0, 0);
        b = q.size();
        run_instr(5'd0, 5'd2, 0, 0);
        q[b].tag = 7;

        for (int i = 0; i < 80; i++) begin
            x = $urandom_range(0, 99);
            fn = r5();
            if (x < 25)      begin op = 5'd0; fn = 5'($urandom_range(0, 5)); end
            else if (x < 45) op = 5'd5;
            else if (x < 65) op = 5'd7;
            else if (x < 88) op = 5'd8;
            else if (x < 94) begin op = 5'd0; fn = 5'($urandom_range(6, 31)); end
            else             op = 5'($urandom_range(9, 31));
            x  = $urandom_range(0, 19);
            wf = (x < 10) ? 0 : (x < 18) ? $urandom_range(1, TO - 1) : TO;
            x  = $urandom_range(0, 19);
            wm = (x < 10) ? 0 : (x < 18) ? $urandom_range(1, TO - 1) : TO;
            if ($urandom_range(0, 11) == 0) gen_abort(op, fn, wf, wm, $urandom_range(1, 4));
            else                            run_instr(op, fn, wf, wm);
        end

        chk("lw_len", 32'(lw_len), 32'd8);

        for (int k = 0; k < q.size(); k++) begin
            @(posedge clock);
            #1;
            reset    = q[k].rst;
            imem_ack = q[k].ia;
            dmem_ack = q[k].da;
            opcode   = q[k].op;
            func     = q[k].fn;
            cur      = k;
            active   = 1'b1;
        end
        @(posedge clock);
        #1;
        active = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
